// File: rtl/accel_poll_ctrl_pkg.sv
// Shared types and constants for the accelerometer polling controller:
// FSM states, register map, init payloads and command-word builders.
package accel_poll_ctrl_pkg;

   typedef enum logic [2:0] {
      INIT_REQ,
      INIT_WAIT,
      IDLE,
      RD_REQ,
      RD_WAIT,
      PUBLISH
   } state_e;

   localparam logic [5:0] REG_BW_RATE     = 6'h2C;
   localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
   localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
   localparam logic [5:0] REG_DATAX0      = 6'h32;

   localparam logic [7:0] DATA_FORMAT_VAL = 8'h08;
   localparam logic [7:0] BW_RATE_VAL     = 8'h0A;
   localparam logic [7:0] POWER_CTL_VAL   = 8'h08;

   localparam int INIT_STEPS = 3;
   localparam int READ_STEPS = 6;

   // {R/nW, MB=0, addr[5:0], data[7:0]}
   function automatic logic [15:0] cmd_word(input logic rnw, input logic [5:0] addr,
                                            input logic [7:0] data);
      return {rnw, 1'b0, addr, data};
   endfunction

   function automatic logic [15:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0:    return cmd_word(1'b0, REG_DATA_FORMAT, DATA_FORMAT_VAL);
         3'd1:    return cmd_word(1'b0, REG_BW_RATE, BW_RATE_VAL);
         default: return cmd_word(1'b0, REG_POWER_CTL, POWER_CTL_VAL);
      endcase
   endfunction

   function automatic logic [15:0] read_cmd(input logic [2:0] idx);
      return cmd_word(1'b1, REG_DATAX0 + 6'(idx), 8'h00);
   endfunction

endpackage

// File: rtl/accel_poll_ctrl_if.sv
// Four-phase request/ack link between the poll controller and the SPI sequencer.
interface accel_poll_ctrl_if;
   logic        req_o;
   logic        ack_i;
   logic [15:0] pachet_trimis;
   logic [7:0]  pachet_primit;

   modport master (output req_o, pachet_trimis, input ack_i, pachet_primit);
   modport slave  (input req_o, pachet_trimis, output ack_i, pachet_primit);
endinterface

// File: rtl/accel_poll_ctrl_tick.sv
// Free-running divider; tick_o pulses for one cycle each time the count wraps.
module poll_tick_gen #(
   parameter int POLL_DIV = 100000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic tick_o
);
   localparam int CW = $clog2(POLL_DIV);

   logic [CW-1:0] cnt_q;
   logic          wrap;

   assign wrap = (cnt_q == CW'(POLL_DIV - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
         tick_o <= wrap;
      end
   end
endmodule

// File: rtl/accel_poll_ctrl.sv
// Accelerometer poll controller: one-shot register init, then periodic 6-byte
// axis reads published atomically, with an ack watchdog that forces re-init.
module accel_poll_ctrl
   import accel_poll_ctrl_pkg::*;
#(
   parameter int POLL_DIV    = 100000,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                enable_i,
   accel_poll_ctrl_if.master   bus,
   output logic signed [15:0]  x_o,
   output logic signed [15:0]  y_o,
   output logic signed [15:0]  z_o,
   output logic                sample_valid_o,
   output logic                init_done_o,
   output logic                err_o
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [TW-1:0]   to_cnt_q;
   logic            pending_q, tick;
   logic [5:0][7:0] shadow_q;

   logic        req_set, ack_take, rd_capture, timeout, start_rd, publish, init_fin;
   logic        to_hit;
   logic [15:0] cmd_d;

   poll_tick_gen #(.POLL_DIV(POLL_DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .tick_o (tick)
   );

   assign to_hit = (to_cnt_q == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= INIT_REQ;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      req_set    = 1'b0;
      ack_take   = 1'b0;
      rd_capture = 1'b0;
      timeout    = 1'b0;
      start_rd   = 1'b0;
      publish    = 1'b0;
      init_fin   = 1'b0;
      cmd_d      = '0;
      case (state_q)
         // a new request only rises once the previous ack has been seen low
         INIT_REQ: if (!bus.ack_i) begin
            req_set = 1'b1;
            cmd_d   = init_cmd(idx_q);
            state_d = INIT_WAIT;
         end
         INIT_WAIT: begin
            if (bus.ack_i) begin
               ack_take = 1'b1;
               if (idx_q == 3'(INIT_STEPS - 1)) begin
                  init_fin = 1'b1;
                  idx_d    = '0;
                  state_d  = IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = INIT_REQ;
               end
            end else if (to_hit) begin
               timeout = 1'b1;
            end
         end
         IDLE: if (pending_q && enable_i) begin
            start_rd = 1'b1;
            idx_d    = '0;
            state_d  = RD_REQ;
         end
         RD_REQ: if (!bus.ack_i) begin
            req_set = 1'b1;
            cmd_d   = read_cmd(idx_q);
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.ack_i) begin
               ack_take   = 1'b1;
               rd_capture = 1'b1;
               if (idx_q == 3'(READ_STEPS - 1)) begin
                  idx_d   = '0;
                  state_d = PUBLISH;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = RD_REQ;
               end
            end else if (to_hit) begin
               timeout = 1'b1;
            end
         end
         PUBLISH: begin
            publish = 1'b1;
            state_d = IDLE;
         end
         default: begin
            idx_d   = '0;
            state_d = INIT_REQ;
         end
      endcase
      if (timeout) begin
         idx_d   = '0;
         state_d = INIT_REQ;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bus.req_o         <= 1'b0;
         bus.pachet_trimis <= '0;
         to_cnt_q          <= '0;
         pending_q         <= 1'b0;
         shadow_q          <= '0;
         x_o               <= '0;
         y_o               <= '0;
         z_o               <= '0;
         sample_valid_o    <= 1'b0;
         init_done_o       <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         sample_valid_o <= publish;
         if (req_set) begin
            bus.req_o         <= 1'b1;
            bus.pachet_trimis <= cmd_d;
            to_cnt_q          <= '0;
         end else if (ack_take || timeout) begin
            bus.req_o <= 1'b0;
         end else if (bus.req_o) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         // one-deep: a wrap arriving while already pending is lost
         if (start_rd)  pending_q <= 1'b0;
         else if (tick) pending_q <= 1'b1;
         if (rd_capture) shadow_q[idx_q] <= bus.pachet_primit;
         if (publish) begin
            x_o <= {shadow_q[1], shadow_q[0]};
            y_o <= {shadow_q[3], shadow_q[2]};
            z_o <= {shadow_q[5], shadow_q[4]};
         end
         if (timeout)       init_done_o <= 1'b0;
         else if (init_fin) init_done_o <= 1'b1;
         if (timeout) err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_accel_poll_ctrl.sv
// Directed bench: behavioural SPI responder plus handshake monitor around one
// accel_poll_ctrl instance (POLL_DIV=64, ACK_TIMEOUT=32).
module tb_accel_poll_ctrl;
   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   logic enable_i = 1'b0;
   logic signed [15:0] x_o, y_o, z_o;
   logic sample_valid_o, init_done_o, err_o;

   accel_poll_ctrl_if bus ();

   accel_poll_ctrl #(.POLL_DIV(64), .ACK_TIMEOUT(32)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .enable_i      (enable_i),
      .bus           (bus),
      .x_o           (x_o),
      .y_o           (y_o),
      .z_o           (z_o),
      .sample_valid_o(sample_valid_o),
      .init_done_o   (init_done_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass = 0, n_total = 0;
   logic [15:0] cmd_log[$];
   int ack_dly = 8, ack_hold = 1, ack_cnt = 0, drop_len = 0;
   logic [7:0] rd_base = 8'h11;
   logic [5:0] drop_addr = 6'h00;
   logic drop_arm = 1'b0;
   int hs_viol = 0, sv_cnt = 0, req_rise = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] getc(input int i);
      return (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx;
   endfunction

   // responder: acks ack_dly cycles after req, optionally ignores one address
   initial begin
      logic [15:0] cmd;
      logic [7:0]  off;
      bus.ack_i = 1'b0;
      bus.pachet_primit = 8'h00;
      forever begin
         @(negedge clk_i);
         if (bus.req_o === 1'b1 && rst_n_i) begin
            cmd = bus.pachet_trimis;
            cmd_log.push_back(cmd);
            if (drop_arm && cmd[13:8] == drop_addr) begin
               drop_arm = 1'b0;
               drop_len = 0;
               while (bus.req_o === 1'b1 && drop_len < 1000) begin
                  drop_len++;
                  @(negedge clk_i);
               end
            end else begin
               for (int i = 1; i < ack_dly && bus.req_o === 1'b1; i++) @(negedge clk_i);
               if (bus.req_o === 1'b1) begin
                  off = {2'b00, cmd[13:8] - 6'h32};
                  bus.pachet_primit = cmd[15] ? rd_base + off : 8'h00;
                  bus.ack_i = 1'b1;
                  ack_cnt++;
                  for (int i = 0; i < ack_hold; i++) begin
                     @(negedge clk_i);
                     bus.pachet_primit = 8'hEE;
                  end
                  bus.ack_i = 1'b0;
               end
            end
         end
      end
   end

   // handshake monitor: rise only after ack low, drop right after ack, cmd stable
   initial begin
      logic        req_prev;
      logic [15:0] cmd_prev;
      req_prev = 1'b0;
      cmd_prev = '0;
      forever begin
         @(posedge clk_i);
         #2;
         if (!rst_n_i) begin
            req_prev = 1'b0;
         end else begin
            if (bus.req_o && !req_prev) begin
               req_rise++;
               if (bus.ack_i) hs_viol++;
            end
            if (req_prev && bus.ack_i && bus.req_o) hs_viol++;
            if (req_prev && bus.req_o && bus.pachet_trimis != cmd_prev) hs_viol++;
            if (sample_valid_o) sv_cnt++;
            req_prev = bus.req_o;
            cmd_prev = bus.pachet_trimis;
         end
      end
   end

   initial begin
      int sv0, r0, a0, l0;
      // reset state
      repeat (3) @(negedge clk_i);
      chk("rst_req", bus.req_o, 1'b0);
      chk("rst_cmd", bus.pachet_trimis, 16'h0000);
      chk("rst_x", x_o, 16'h0000);
      chk("rst_sv", sample_valid_o, 1'b0);
      chk("rst_done", init_done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);

      // init sequence with 8-cycle responder
      rst_n_i = 1'b1;
      for (int i = 0; i < 300 && !init_done_o; i++) @(negedge clk_i);
      chk("init_done", init_done_o, 1'b1);
      chk("init_ncmd", cmd_log.size(), 3);
      chk("init_c0", getc(0), 16'h3108);
      chk("init_c1", getc(1), 16'h2C0A);
      chk("init_c2", getc(2), 16'h2D08);

      // first read set
      ack_dly = 2; rd_base = 8'h11; sv0 = sv_cnt;
      enable_i = 1'b1;
      for (int i = 0; i < 400 && sv_cnt == sv0; i++) @(negedge clk_i);
      enable_i = 1'b0;
      chk("rd1_x", x_o, 16'h1211);
      chk("rd1_y", y_o, 16'h1413);
      chk("rd1_z", z_o, 16'h1615);
      for (int k = 0; k < 6; k++) chk("rd1_cmd", getc(3 + k), 16'hB200 + 16'(k << 8));
      repeat (20) @(negedge clk_i);
      chk("rd1_one_pulse", sv_cnt, sv0 + 1);

      // ack held 5 cycles: one byte per transaction, no early re-request
      ack_hold = 5; rd_base = 8'h21; sv0 = sv_cnt; r0 = req_rise;
      enable_i = 1'b1;
      for (int i = 0; i < 600 && sv_cnt == sv0; i++) @(negedge clk_i);
      enable_i = 1'b0;
      chk("hold_x", x_o, 16'h2221);
      chk("hold_y", y_o, 16'h2423);
      chk("hold_z", z_o, 16'h2625);
      chk("hold_nreq", req_rise - r0, 6);
      chk("hold_hs", hs_viol, 0);

      // enable dropped after third ack: set completes, then stays quiet
      ack_hold = 1; rd_base = 8'h31; sv0 = sv_cnt; a0 = ack_cnt;
      enable_i = 1'b1;
      for (int i = 0; i < 400 && ack_cnt < a0 + 3; i++) @(negedge clk_i);
      enable_i = 1'b0;
      for (int i = 0; i < 200 && sv_cnt == sv0; i++) @(negedge clk_i);
      chk("en_x", x_o, 16'h3231);
      chk("en_y", y_o, 16'h3433);
      chk("en_z", z_o, 16'h3635);
      r0 = req_rise; sv0 = sv_cnt;
      repeat (3 * 64 + 10) @(negedge clk_i);
      chk("en_noreq", req_rise, r0);
      chk("en_nosv", sv_cnt, sv0);

      // no ack on the second read: watchdog fires and init restarts
      l0 = cmd_log.size(); rd_base = 8'h41; drop_addr = 6'h33; drop_arm = 1'b1;
      enable_i = 1'b1;
      for (int i = 0; i < 400 && !err_o; i++) @(negedge clk_i);
      enable_i = 1'b0;
      chk("to_err", err_o, 1'b1);
      chk("to_len", drop_len, 32);
      chk("to_req", bus.req_o, 1'b0);
      chk("to_done", init_done_o, 1'b0);
      chk("to_x", x_o, 16'h3231);
      for (int i = 0; i < 300 && !init_done_o; i++) @(negedge clk_i);
      chk("to_c0", getc(l0), 16'hB200);
      chk("to_c1", getc(l0 + 1), 16'hB300);
      chk("to_next", getc(l0 + 2), 16'h3108);
      chk("to_redone", init_done_o, 1'b1);
      chk("to_sticky", err_o, 1'b1);
      chk("to_x2", x_o, 16'h3231);

      // asynchronous reset while a read request is outstanding
      ack_dly = 20;
      enable_i = 1'b1;
      for (int i = 0; i < 300 && !(bus.req_o === 1'b1 && bus.pachet_trimis[15]); i++)
         @(negedge clk_i);
      chk("ar_req_hi", bus.req_o, 1'b1);
      #3 rst_n_i = 1'b0;
      enable_i = 1'b0;
      #1;
      chk("ar_req", bus.req_o, 1'b0);
      chk("ar_cmd", bus.pachet_trimis, 16'h0000);
      chk("ar_x", x_o, 16'h0000);
      chk("ar_z", z_o, 16'h0000);
      chk("ar_err", err_o, 1'b0);
      chk("ar_done", init_done_o, 1'b0);
      repeat (3) @(negedge clk_i);
      ack_dly = 8;
      l0 = cmd_log.size();
      rst_n_i = 1'b1;
      for (int i = 0; i < 300 && !init_done_o; i++) @(negedge clk_i);
      chk("ar_init", getc(l0), 16'h3108);
      chk("ar_ncmd", cmd_log.size(), l0 + 3);
      chk("ar_err2", err_o, 1'b0);
      chk("hs_total", hs_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/accel_poll_ctrl.md
ACCEL_POLL_CTRL -- requirements
Module: accel_poll_ctrl

Interface
REQ-001 Parameter POLL_DIV, default 100000, clk_i cycles between sample-set starts (>=16).
REQ-002 Parameter ACK_TIMEOUT, default 4096, clk_i cycles allowed from req_o rise to ack_i high.
REQ-003 clk_i  in  1  single clock (PLL c0 domain); all logic rising-edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 enable_i  in  1  1 = periodic polling allowed.
REQ-006 req_o  out  1  transaction request to SPI sequencer.
REQ-007 ack_i  in  1  transaction complete from SPI sequencer.
REQ-008 pachet_trimis  out  16  command: [15]=R/nW, [14]=MB (always 0), [13:8]=register address, [7:0]=write data (0x00 for reads).
REQ-009 pachet_primit  in  8  read byte, valid in the cycle ack_i is high.
REQ-010 x_o, y_o, z_o  out  16 each  signed axis samples, {high byte, low byte}.
REQ-011 sample_valid_o  out  1  one-cycle pulse when x_o/y_o/z_o update.
REQ-012 init_done_o  out  1  configuration sequence completed.
REQ-013 err_o  out  1  sticky ack-timeout flag.

Function
REQ-014 Four-phase handshake: pachet_trimis is stable from req_o rise until ack_i is sampled high; req_o deasserts the cycle after ack_i is sampled high; the next req_o rises only after ack_i is sampled low.
REQ-015 The 3-step init sequence is fixed: write 0x31<=0x08, then 0x2C<=0x0A, then 0x2D<=0x08 (cmd words 0x3108, 0x2C0A, 0x2D08).
REQ-016 The 6-step read sequence is fixed: read 0x32..0x37 in ascending order (cmd words 0xB200..0xB700).
REQ-017 FSM states: INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, PUBLISH; a step index (0..2 init, 0..5 read) selects the command.
REQ-018 After reset: INIT_REQ with index 0; init runs regardless of enable_i; after the third ack, init_done_o=1 and the FSM enters IDLE.
REQ-019 A free-running tick counter wraps every POLL_DIV cycles; a wrap sets a one-deep pending flag; further wraps while pending are dropped.
REQ-020 IDLE->RD_REQ when pending=1 and enable_i=1; the pending flag clears on that transition.
REQ-021 Each read ack stores pachet_primit into a shadow byte; x_o/y_o/z_o are not modified during a read set.
REQ-022 PUBLISH (one cycle after the 6th ack) copies all shadows to x_o={0x33,0x32}, y_o={0x35,0x34}, z_o={0x37,0x36} atomically and pulses sample_valid_o; it then returns to IDLE.
REQ-023 enable_i falling mid-set does not abort; the set completes and publishes; no new set starts while enable_i=0.
REQ-024 Timeout: if ack_i is not high within ACK_TIMEOUT cycles of req_o rise, req_o drops, err_o sets (sticky until reset), and the FSM restarts at INIT_REQ index 0 with init_done_o=0.
REQ-025 ack_i high when not in a WAIT state is ignored.

Reset
REQ-026 On reset: req_o=0, pachet_trimis=0x0000, x_o=y_o=z_o=0, sample_valid_o=0, init_done_o=0, err_o=0, pending=0, tick counter=0, shadows=0, state=INIT_REQ index 0.
REQ-027 Reset asserted mid-transaction drops req_o immediately (asynchronously), without waiting for ack_i.

Structure
REQ-028 A shared package holds the state enum, register addresses (0x2C, 0x2D, 0x31, 0x32) and init data constants.
REQ-029 The tick divider is a separate sub-module poll_tick_gen (POLL_DIV parameter, one-cycle tick_o).

Verification
REQ-030 Reset release with a responder that acks 8 cycles after each req -> cmds 0x3108, 0x2C0A, 0x2D08 in order; init_done_o=1 after the 3rd ack.
REQ-031 POLL_DIV=64, enable_i=1, responder returns bytes 0x11..0x16 -> a 0xB200..0xB700 sequence, then x_o=0x1211, y_o=0x1413, z_o=0x1615 with a single sample_valid_o pulse.
REQ-032 Responder holds ack_i high for 5 cycles -> no second req_o until ack_i is low; exactly one byte is captured per transaction.
REQ-033 ACK_TIMEOUT=32 with no ack on the 2nd read -> req_o drops at cycle 32, err_o=1, the next cmd is 0x3108, and x_o is unchanged.
REQ-034 enable_i dropped after the 3rd read ack -> the set finishes and publishes; no req_o occurs for the next 3 ticks.
REQ-035 rst_n_i pulsed low while req_o=1 -> req_o=0 in the same cycle; all outputs hold their reset values; init restarts on release.
